// File: rtl/mx_pkg.sv
// ---------------------------------------------------------------------------
// mx_pkg
// Shared types and helpers for the MX block-scale front end.
//   mx_state_t  : two-state controller encoding (FILL collects a block,
//                 DRAIN replays it with per-element shift amounts).
//   clamp_shift : limits an exponent difference to width_i+1, the value the
//                 downstream round stage treats as "flush to zero".
// ---------------------------------------------------------------------------
package mx_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } mx_state_t;

  // Any difference beyond width_i+1 shifts every mantissa bit out anyway,
  // so all larger values collapse onto the single flush code.
  function automatic int unsigned clamp_shift(input int unsigned diff,
                                              input int unsigned width_i);
    if (diff > width_i + 1) begin
      return width_i + 1;
    end
    return diff;
  endfunction

endpackage

// File: rtl/mx_blk_buf.sv
// ---------------------------------------------------------------------------
// mx_blk_buf
// Block storage for one MX block: block_size entries of (width_i+width_e)
// bits, one synchronous write port and one asynchronous read port.
// Ports:
//   i_clk     clock
//   i_we      write enable
//   i_waddr   write address
//   i_wdata   write data {mantissa, exponent}
//   i_raddr   read address
//   o_rdata   read data, combinational from i_raddr
// ---------------------------------------------------------------------------
module mx_blk_buf #(
  parameter int block_size = 32,
  parameter int width_d    = 17,
  parameter int width_a    = $clog2(block_size)
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [width_a-1:0] i_waddr,
  input  logic [width_d-1:0] i_wdata,
  input  logic [width_a-1:0] i_raddr,
  output logic [width_d-1:0] o_rdata
);

  logic [width_d-1:0] mem_q [block_size];

  // NOTE: storage has no reset on purpose; every entry is written in FILL
  // before DRAIN can read it, and a reset would block LUTRAM mapping.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/mx_shared_exp.sv
// ---------------------------------------------------------------------------
// mx_shared_exp
// Block-scale front end for MX quantisation. Collects block_size elements
// (signed mantissa + biased exponent), computes the shared exponent as the
// maximum element exponent, then replays the block in order with a
// per-element right-shift amount for the downstream RNE round stage.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_valid/o_ready   input element handshake
//   i_num, i_exp      input mantissa (two's complement) and biased exponent
//   o_valid/i_ready   output element handshake
//   o_num             buffered mantissa, unmodified
//   o_shift           min(o_scale - exp, width_i+1)
//   o_scale           shared exponent of the block being replayed
//   o_last            final element of the block
// ---------------------------------------------------------------------------
module mx_shared_exp
  import mx_pkg::*;
#(
  parameter int width_i     = 9,
  parameter int width_e     = 8,
  parameter int block_size  = 32,
  parameter int width_shift = $clog2(width_i + 2)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [width_i-1:0]     i_num,
  input  logic [width_e-1:0]     i_exp,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [width_i-1:0]     o_num,
  output logic [width_shift-1:0] o_shift,
  output logic [width_e-1:0]     o_scale,
  output logic                   o_last
);

  localparam int              width_a  = $clog2(block_size);
  localparam int              width_d  = width_i + width_e;
  localparam logic [width_a-1:0] last_idx = width_a'(block_size - 1);

  mx_state_t          state_q, state_d;
  logic [width_a-1:0] wr_cnt_q, wr_cnt_d;
  logic [width_a-1:0] rd_cnt_q, rd_cnt_d;
  logic [width_e-1:0] max_q, max_d;
  logic [width_e-1:0] scale_q, scale_d;

  logic               in_xfer;
  logic               out_xfer;
  logic               rd_last;
  logic [width_d-1:0] rd_data;
  logic [width_i-1:0] rd_num;
  logic [width_e-1:0] rd_exp;
  logic [width_e-1:0] exp_diff;
  logic [width_e-1:0] max_next;

  // -------------------------------------------------------------------------
  // Handshakes. Input and output are mutually exclusive by state, so the
  // buffer never sees a read and a write to the same block concurrently.
  // -------------------------------------------------------------------------
  assign o_ready  = (state_q == FILL)  && !i_rst;
  assign o_valid  = (state_q == DRAIN) && !i_rst;
  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;
  assign rd_last  = (rd_cnt_q == last_idx);

  mx_blk_buf #(
    .block_size (block_size),
    .width_d    (width_d),
    .width_a    (width_a)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    (in_xfer),
    .i_waddr (wr_cnt_q),
    .i_wdata ({i_num, i_exp}),
    .i_raddr (rd_cnt_q),
    .o_rdata (rd_data)
  );

  assign rd_num = rd_data[width_d-1:width_e];
  assign rd_exp = rd_data[width_e-1:0];

  // Element 0 seeds the max so nothing from a previous or discarded block
  // can leak into this block's scale.
  assign max_next = (wr_cnt_q == '0)  ? i_exp :
                    (i_exp > max_q)   ? i_exp : max_q;

  // scale_q is the max of the replayed block, so the subtract cannot wrap.
  assign exp_diff = scale_q - rd_exp;

  // Outputs are forced to zero outside DRAIN so the buffer's unreset
  // contents never appear on the port.
  assign o_num   = o_valid ? rd_num : '0;
  assign o_shift = o_valid
                 ? width_shift'(clamp_shift(32'(exp_diff), 32'(width_i)))
                 : '0;
  assign o_last  = o_valid && rd_last;
  assign o_scale = scale_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    max_d    = max_q;
    scale_d  = scale_q;

    unique case (state_q)
      FILL: begin
        if (in_xfer) begin
          max_d = max_next;
          if (wr_cnt_q == last_idx) begin
            wr_cnt_d = '0;
            scale_d  = max_next;
            state_d  = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_xfer) begin
          if (rd_last) begin
            rd_cnt_d = '0;
            state_d  = FILL;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      max_q    <= '0;
      scale_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      max_q    <= max_d;
      scale_q  <= scale_d;
    end
  end

endmodule
